// File: rtl/rom_glyph_serializer.sv
// rom_glyph_serializer: fetch stage in front of a single-port character ROM
// with registered 1-cycle-latency data. A {char, line} request is accepted
// over valid/ready. The fetched byte is parked in a one-entry buffer and then
// shifted out MSB-first, one pixel per ce_pix pulse. Because the buffer
// refills while the shifter drains, back-to-back requests give a gapless
// pixel stream.
// Optional build macro: PIXEL_DOUBLE_EN holds each pixel for two ce_pix pulses.
module rom_glyph_serializer #(
  parameter int unsigned address_width = 11,
  parameter int unsigned data_width    = 8,
  parameter int unsigned line_bits     = 3
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 ce_pix,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [address_width-line_bits-1:0]   req_char,
  input  logic [line_bits-1:0]                 req_line,
  output logic [address_width-1:0]             rom_address,
  input  logic [data_width-1:0]                rom_q,
  output logic                                 pix,
  output logic                                 pix_valid,
  output logic                                 busy
);

  localparam int unsigned CNT_W = $clog2(data_width + 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_ADDR,
    F_DATA
  } fetch_state_e;

  fetch_state_e               state_q, state_d;
  logic [address_width-1:0]   addr_q, addr_d;
  logic [data_width-1:0]      hold_q, hold_d;
  logic                       buf_full_q, buf_full_d;
  logic [data_width-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic capture;
  logic drain;
  logic cnt_zero;
  logic cnt_last;
  logic advance;

`ifdef PIXEL_DOUBLE_EN
  // Phase 0 = first pulse of a pixel, phase 1 = second pulse (the one that moves the shifter).
  logic phase_q, phase_d;
  assign advance = phase_q;
`else
  assign advance = 1'b1;
`endif

  assign cnt_zero = (count_q == '0);
  assign cnt_last = (count_q == CNT_W'(1));

  // Fetch FSM: issue the ROM address, wait for the registered data, capture it into the buffer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req_ready = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      F_IDLE: begin
        req_ready = reset_n & ~buf_full_q;
        if (req_valid && reset_n && !buf_full_q) begin
          addr_d  = {req_char, req_line};
          state_d = F_ADDR;
        end
      end
      F_ADDR: begin
        state_d = F_DATA;
      end
      F_DATA: begin
        capture = 1'b1;
        state_d = F_IDLE;
      end
      default: begin
        state_d = F_IDLE;
      end
    endcase
  end

  // Shifter: load from the buffer when empty, or reload on the last pixel so the stream has no gap.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    drain   = 1'b0;
`ifdef PIXEL_DOUBLE_EN
    phase_d = phase_q;
`endif
    if (ce_pix) begin
      if (cnt_zero) begin
        if (buf_full_q) begin
          shift_d = hold_q;
          count_d = CNT_W'(data_width);
          drain   = 1'b1;
`ifdef PIXEL_DOUBLE_EN
          phase_d = 1'b0;
`endif
        end
      end else if (advance) begin
        if (cnt_last && buf_full_q) begin
          shift_d = hold_q;
          count_d = CNT_W'(data_width);
          drain   = 1'b1;
        end else begin
          shift_d = shift_q << 1;
          count_d = count_q - CNT_W'(1);
        end
`ifdef PIXEL_DOUBLE_EN
        phase_d = 1'b0;
`endif
      end else begin
`ifdef PIXEL_DOUBLE_EN
        phase_d = 1'b1;
`endif
      end
    end
  end

  // Holding buffer: a capture can never coincide with a drain (accept requires an empty
  // buffer), but capture is given priority so a simultaneous pair would keep it full.
  always_comb begin
    hold_d     = hold_q;
    buf_full_d = buf_full_q;
    if (capture) begin
      hold_d     = rom_q;
      buf_full_d = 1'b1;
    end else if (drain) begin
      buf_full_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; reset discards any fetch, buffer or shift.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= F_IDLE;
      addr_q     <= '0;
      hold_q     <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
    end
  end

`ifdef PIXEL_DOUBLE_EN
  // Pixel-doubling phase register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  assign rom_address = addr_q;
  assign pix_valid   = ~cnt_zero;
  assign pix         = shift_q[data_width-1] & pix_valid;
  assign busy        = (state_q != F_IDLE) | buf_full_q | pix_valid;

endmodule

// File: tb/tb_rom_glyph_serializer.sv
// Self-checking bench for rom_glyph_serializer with a behavioural 1-cycle ROM.
module tb_rom_glyph_serializer;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int LB = 3;
  localparam int CW = AW - LB;
`ifdef PIXEL_DOUBLE_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_pix = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CW-1:0] req_char = '0;
  logic [LB-1:0] req_line = '0;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q;
  logic          pix;
  logic          pix_valid;
  logic          busy;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= mem[rom_address];

  rom_glyph_serializer #(
    .address_width(AW),
    .data_width(DW),
    .line_bits(LB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .ce_pix(ce_pix),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_char(req_char),
    .req_line(req_line),
    .rom_address(rom_address),
    .rom_q(rom_q),
    .pix(pix),
    .pix_valid(pix_valid),
    .busy(busy)
  );

  typedef struct {
    logic [CW-1:0] ch;
    logic [LB-1:0] ln;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request from a negedge; return at the negedge after the accepting edge.
  task automatic send(input logic [CW-1:0] c, input logic [LB-1:0] l);
    int n;
    n = 0;
    req_char  = c;
    req_line  = l;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("req_accept_in_time", 32'(n < 64), 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (pix_valid !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Starting at the first valid sample, compare nbits pixels each held for hold cycles.
  task automatic expect_stream(input string name, input logic [15:0] bits, input int nbits, input int hold);
    int errs;
    logic expb;
    errs = 0;
    for (int i = 0; i < nbits * hold; i++) begin
      expb = bits[nbits - 1 - i / hold];
      if (pix_valid !== 1'b1 || pix !== expb) begin
        if (errs == 0) $display("FAIL %s: sample %0d got valid=%b pix=%b expected valid=1 pix=%b", name, i, pix_valid, pix, expb);
        errs++;
      end
      @(negedge clock);
    end
    check(name, 32'(errs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hs;
    int errs;
    int j;
    logic [7:0] sp;

    for (int unsigned a = 0; a < (1 << AW); a++) mem[a] = DW'(a) ^ 8'h5A;

    vecs[0] = '{ch: 8'h41, ln: 3'd3, data: 8'hA5, addr: 11'h20B};
    vecs[1] = '{ch: 8'hFF, ln: 3'd7, data: 8'h80, addr: 11'h7FF};
    vecs[2] = '{ch: 8'h00, ln: 3'd0, data: 8'h01, addr: 11'h000};
    vecs[3] = '{ch: 8'h55, ln: 3'd4, data: 8'h00, addr: 11'h2AC};
    vecs[4] = '{ch: 8'h2A, ln: 3'd6, data: 8'h6E, addr: 11'h156};
    for (int i = 0; i < 5; i++) mem[vecs[i].addr] = vecs[i].data;
    mem[11'h080] = 8'hFF;
    mem[11'h115] = 8'h81;
    mem[11'h029] = 8'hC3;
    mem[11'h19A] = 8'h3C;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rom_address", 32'(rom_address), 32'h0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Single requests from the table, ce_pix constantly high
    ce_pix = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].ch, vecs[i].ln);
      check($sformatf("vec%0d_rom_address", i), 32'(rom_address), 32'(vecs[i].addr));
      check($sformatf("vec%0d_ready_low_in_fetch", i), 32'(req_ready), 32'd0);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      expect_stream($sformatf("vec%0d_pixels", i), {8'h00, vecs[i].data}, 8, REP);
      check($sformatf("vec%0d_valid_fall", i), 32'(pix_valid), 32'd0);
      check($sformatf("vec%0d_pix_idle", i), 32'(pix), 32'd0);
      check($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'd0);
    end

    // Back-to-back requests: 16 contiguous pixels
    fork
      begin
        send(8'h10, 3'd0);
        send(8'h22, 3'd5);
      end
      begin
        int blat;
        wait_valid(blat);
        check("b2b_start_in_time", 32'(blat < 100), 32'd1);
        expect_stream("b2b_pixels", 16'hFF81, 16, REP);
        check("b2b_valid_fall", 32'(pix_valid), 32'd0);
      end
    join
    @(negedge clock);
    check("b2b_busy_idle", 32'(busy), 32'd0);

    // Sparse ce_pix: one pulse every 4 cycles
    ce_pix = 1'b0;
    send(8'h05, 3'd1);
    repeat (3) @(negedge clock);
    check("sparse_ready_while_full", 32'(req_ready), 32'd0);
    check("sparse_busy_while_full", 32'(busy), 32'd1);
    check("sparse_no_pixel_yet", 32'(pix_valid), 32'd0);
    sp = 8'hC3;
    errs = 0;
    for (int k = 0; k <= 32 * REP + 1; k++) begin
      if (k == 0) begin
        if (pix_valid !== 1'b0) errs++;
      end else begin
        j = (k - 1) / (4 * REP);
        if (j < 8) begin
          if (pix_valid !== 1'b1 || pix !== sp[7 - j]) errs++;
        end else if (pix_valid !== 1'b0 || pix !== 1'b0) begin
          errs++;
        end
      end
      if (k == 1) check("sparse_ready_after_load", 32'(req_ready), 32'd1);
      ce_pix = (k % 4 == 0);
      @(negedge clock);
    end
    check("sparse_pixels", 32'(errs), 32'd0);
    check("sparse_busy_idle", 32'(busy), 32'd0);

    // Backpressure: req_valid held, ce_pix low
    ce_pix    = 1'b0;
    req_char  = 8'h33;
    req_line  = 3'd2;
    req_valid = 1'b1;
    hs = 0;
    repeat (12) begin
      if (req_valid && req_ready) hs++;
      @(negedge clock);
    end
    check("bp_one_accept", 32'(hs), 32'd1);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    check("bp_rom_address", 32'(rom_address), 32'h19A);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_no_pixel", 32'(pix_valid), 32'd0);
    req_valid = 1'b0;
    ce_pix    = 1'b1;
    wait_valid(lat);
    check("bp_load_latency", 32'(lat), 32'd1);
    expect_stream("bp_pixels", 16'h003C, 8, REP);
    check("bp_single_byte", 32'(pix_valid), 32'd0);
    check("bp_busy_idle", 32'(busy), 32'd0);

    // Reset in the middle of shifting 0xFF
    send(8'h10, 3'd0);
    wait_valid(lat);
    check("mid_rst_started", 32'(pix_valid), 32'd1);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_pix", 32'(pix), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rom_address", 32'(rom_address), 32'h0);
    check("mid_rst_ready_low", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("mid_rst_ready_after", 32'(req_ready), 32'd1);
    errs = 0;
    repeat (10) begin
      if (pix_valid !== 1'b0 || busy !== 1'b0) errs++;
      @(negedge clock);
    end
    check("mid_rst_shift_discarded", 32'(errs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
